alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// Issue/writeback controller driving the combinational ALU of PIGRO. Accepts 32-bit instruction words
// over valid/ready, decodes them, reads operands from an internal register file and presents
// opcode/data_a/data_b/enable to the ALU. It then captures ALUout/overflow/error and writes the result back.
// Sits between fetch and the ALU; one instruction in flight, 3 cycles per instruction.
// PARAMETERS
// DATA_W  32  datapath width; must match ALU width
// AW      4   register address width (2**AW registers, r0 reads as 0)
// IMM_W   14  immediate field width; 5+3*AW+1+IMM_W must equal 32
// PORTS
// clk          in   1       clock, all state on rising edge
// reset        in   1       synchronous, active-high
// instr        in   32      [31:27] opcode (opcodes.vh), [26:23] rd, [22:19] ra, [18:15] rb, [14] imm_sel, [13:0] imm
// instr_valid  in   1       instr is valid
// instr_ready  out  1       block can accept instr this cycle
// alu_opcode   out  5       to ALU opcode
// alu_data_a   out  DATA_W  to ALU data_a
// alu_data_b   out  DATA_W  to ALU data_b
// alu_enable   out  1       to ALU enable
// alu_result   in   DATA_W  from ALU ALUout
// alu_overflow in   1       from ALU overflow
// alu_error    in   1       from ALU error
// clear_flags  in   1       clears sticky flags
// done         out  1       one-cycle pulse: instruction retired
// done_err     out  1       qualifies done: retired with opcode error, no writeback
// ovf_flag     out  1       sticky overflow
// err_flag     out  1       sticky opcode error
// dbg_addr     in   AW      debug register read address
// dbg_data     out  DATA_W  combinational read of reg[dbg_addr] (0 for r0)
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, all registers r0..r15=0, instr latch=0.
//   Outputs on reset: alu_enable=0, alu_opcode=0, alu_data_a/b=0, done=0, done_err=0, ovf_flag=0, err_flag=0.
// - Reset mid-operation: an instruction in flight is discarded with no writeback and no done pulse.
// - FSM: IDLE -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
// - IDLE: if instr_valid&&instr_ready, latch instr, go EXEC; otherwise stay. instr is ignored while not ready.
// - EXEC: alu_enable=1, alu_opcode=instr[31:27], alu_data_a=reg[ra].
//   alu_data_b=reg[rb] if imm_sel=0, else sign-extended imm to DATA_W.
//   At the cycle end, register alu_result, alu_overflow and alu_error; go WB.
// - Outside EXEC: alu_enable=0, alu_opcode/data held at 0 (the disabled ALU outputs 0).
// - WB: done=1 for exactly one cycle, done_err=captured error.
//   Write reg[rd]=captured result unless error=1, opcode==NOP, or rd==0; go IDLE.
// - Sticky flags: ovf_flag|=overflow, err_flag|=error in WB.
//   Overflow does not suppress writeback.
//   clear_flags clears both. A flag set in the same WB cycle as clear_flags wins (flag ends at 1).
// - Single-operand ops (NOT, INC, DEC, ROTL, ROTR) still drive alu_data_b per the rules above.
// - Shifts pass the full reg[rb] or immediate as the shift amount; no masking here.
// - Latency: accept at cycle T, ALU driven at T+1, done and register write at T+2, instr_ready=1 at T+3.
// - Reading rd at T+3 or later, via dbg_data or a later instruction, returns the new value.
// - Writes to r0 are dropped; reg[0] always reads 0.
// TESTING
// 1 r1=5 (ADD r1,r0,imm 5), then ADD r2,r1,imm -3 -> r2=2, done at T+2, ovf_flag=0.
// 2 r1=0x7FFFFFFF, ADD r3,r1,imm 1 -> r3=0x80000000, ovf_flag=1.
//   clear_flags=1 for one cycle -> ovf_flag=0.
// 3 Unused opcode 5'b11111, rd=4 -> done&&done_err, err_flag=1, r4 unchanged.
// 4 Hold instr_valid=1 continuously with 4 instructions -> accepted every 3rd cycle, exactly 4 done pulses.
// 5 ADD r0,r1,imm 7 and NOP rd=5 -> r0 reads 0, r5 unchanged.
// 6 Assert reset during EXEC of ADD r6 -> no done pulse, r6=0, state IDLE with instr_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback controller for the PIGRO combinational ALU.
// It accepts one instruction, drives the ALU for one cycle and writes the result back.
// The register file is internal; r0 is hardwired to zero.
module alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4,
  parameter int unsigned IMM_W  = 14  // 5 + 3*AW + 1 + IMM_W must equal 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_data_a,
  output logic [DATA_W-1:0] alu_data_b,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic              alu_error,
  input  logic              clear_flags,
  output logic              done,
  output logic              done_err,
  output logic              ovf_flag,
  output logic              err_flag,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NumRegs   = 1 << AW;
  localparam int unsigned ImmSelBit = IMM_W;
  localparam int unsigned RbLsb     = IMM_W + 1;
  localparam int unsigned RaLsb     = RbLsb + AW;
  localparam int unsigned RdLsb     = RaLsb + AW;
  localparam int unsigned OpLsb     = RdLsb + AW;

  localparam logic [4:0] OpNop = 5'd0;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic                err_flag_q, err_flag_d;
  logic [DATA_W-1:0]   regs_q [NumRegs];
  logic [DATA_W-1:0]   regs_d [NumRegs];

  // Decoded fields of the latched instruction.
  logic [4:0]          op;
  logic [AW-1:0]       rd, ra, rb;
  logic                imm_sel;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_ext;
  logic                wb_en;

  assign op      = instr_q[OpLsb +: 5];
  assign rd      = instr_q[RdLsb +: AW];
  assign ra      = instr_q[RaLsb +: AW];
  assign rb      = instr_q[RbLsb +: AW];
  assign imm_sel = instr_q[ImmSelBit];
  assign imm     = instr_q[IMM_W-1:0];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  // Errored, NOP and r0-targeted instructions retire without touching the register file.
  assign wb_en = (state_q == StWb) && !err_q && (op != OpNop) && (rd != '0);

  // State register and all datapath flops; reset discards any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
      err_flag_q <= 1'b0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      ovf_flag_q <= ovf_flag_d;
      err_flag_q <= err_flag_d;
      regs_q     <= regs_d;
    end
  end

  // Next-state logic: IDLE -> EXEC -> WB -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: instruction latch, ALU capture, writeback and sticky flags.
  always_comb begin
    instr_d = instr_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    regs_d  = regs_q;
    if (state_q == StIdle && instr_valid) instr_d = instr;
    if (state_q == StExec) begin
      res_d = alu_result;
      ovf_d = alu_overflow;
      err_d = alu_error;
    end
    if (wb_en) regs_d[rd] = res_q;
    // Clear first so a flag raised in the same WB cycle survives.
    ovf_flag_d = clear_flags ? 1'b0 : ovf_flag_q;
    err_flag_d = clear_flags ? 1'b0 : err_flag_q;
    if (state_q == StWb) begin
      ovf_flag_d = ovf_flag_d | ovf_q;
      err_flag_d = err_flag_d | err_q;
    end
  end

  // Outputs: ALU is driven only in EXEC, otherwise held at zero.
  always_comb begin
    instr_ready = (state_q == StIdle);
    alu_enable  = 1'b0;
    alu_opcode  = '0;
    alu_data_a  = '0;
    alu_data_b  = '0;
    done        = 1'b0;
    done_err    = 1'b0;
    if (state_q == StExec) begin
      alu_enable = 1'b1;
      alu_opcode = op;
      alu_data_a = regs_q[ra];
      alu_data_b = imm_sel ? imm_ext : regs_q[rb];
    end
    if (state_q == StWb) begin
      done     = 1'b1;
      done_err = err_q;
    end
  end

  assign ovf_flag = ovf_flag_q;
  assign err_flag = err_flag_q;
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a small behavioural ALU model.
module tb_alu_issue;

  localparam logic [4:0] OpNop = 5'd0;
  localparam logic [4:0] OpAdd = 5'd1;
  localparam logic [4:0] OpSrl = 5'd9;
  localparam logic [4:0] OpBad = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_data_a, alu_data_b;
  logic        alu_enable;
  logic [31:0] alu_result;
  logic        alu_overflow, alu_error;
  logic        clear_flags;
  logic        done, done_err, ovf_flag, err_flag;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_opcode   (alu_opcode),
    .alu_data_a   (alu_data_a),
    .alu_data_b   (alu_data_b),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_error    (alu_error),
    .clear_flags  (clear_flags),
    .done         (done),
    .done_err     (done_err),
    .ovf_flag     (ovf_flag),
    .err_flag     (err_flag),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Combinational ALU stand-in; NOP returns a nonzero value so a wrong writeback shows up.
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    alu_error    = 1'b0;
    if (alu_enable) begin
      case (alu_opcode)
        OpNop: alu_result = 32'h1234_5678;
        OpAdd: begin
          alu_result   = alu_data_a + alu_data_b;
          alu_overflow = (alu_data_a[31] == alu_data_b[31]) && (alu_result[31] != alu_data_a[31]);
        end
        OpSrl: alu_result = alu_data_a >> alu_data_b;
        default: begin
          alu_result = 32'hDEAD_BEEF;
          alu_error  = 1'b1;
        end
      endcase
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic isel, input logic [13:0] imm);
    return {op, rd, ra, rb, isel, imm};
  endfunction

  // Present one instruction for a single cycle; returns 1ns into the EXEC cycle.
  task automatic send(input logic [31:0] w);
    @(posedge clk); #1;
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Run one instruction to completion; returns 1ns into the first IDLE cycle after WB.
  task automatic exec(input logic [31:0] w);
    send(w);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dbg_addr = 4'd1;
    @(negedge clk);
    tests_run++;
    if ({instr_ready, alu_enable, done, done_err, ovf_flag, err_flag} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {instr_ready, alu_enable, done, done_err, ovf_flag, err_flag});
    end
    tests_run++;
    if ({alu_opcode, alu_data_a, alu_data_b} !== 69'h0) begin
      tests_failed++;
      $display("FAIL reset_alu_bus: got op=%h a=%h b=%h expected all 0",
               alu_opcode, alu_data_a, alu_data_b);
    end
    tests_run++;
    if (dbg_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_r1: got %h expected 0", dbg_data);
    end
  endtask

  task automatic test_add;
    exec(mk(OpAdd, 4'd1, 4'd0, 4'd0, 1'b1, 14'd5));
    dbg_addr = 4'd1;
    #1;
    tests_run++;
    if (dbg_data !== 32'd5) begin
      tests_failed++;
      $display("FAIL add_r1: got %h expected 5", dbg_data);
    end
    dbg_addr = 4'd2;
    send(mk(OpAdd, 4'd2, 4'd1, 4'd0, 1'b1, 14'h3FFD));
    @(negedge clk);  // T+1
    tests_run++;
    if ({alu_enable, alu_opcode, alu_data_a, alu_data_b} !== {1'b1, OpAdd, 32'd5, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("FAIL add_exec_bus: got en=%b op=%h a=%h b=%h expected en=1 op=01 a=5 b=fffffffd",
               alu_enable, alu_opcode, alu_data_a, alu_data_b);
    end
    @(negedge clk);  // T+2
    tests_run++;
    if ({done, done_err, instr_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL add_done: got done/err/ready=%b expected 100", {done, done_err, instr_ready});
    end
    @(negedge clk);  // T+3
    tests_run++;
    if ({dbg_data, ovf_flag, done, instr_ready} !== {32'd2, 3'b001}) begin
      tests_failed++;
      $display("FAIL add_result: got r2=%h ovf=%b done=%b ready=%b expected r2=2 ovf=0 done=0 ready=1",
               dbg_data, ovf_flag, done, instr_ready);
    end
  endtask

  task automatic test_overflow;
    exec(mk(OpAdd, 4'd1, 4'd0, 4'd0, 1'b1, 14'h3FFF));
    exec(mk(OpSrl, 4'd1, 4'd1, 4'd0, 1'b1, 14'd1));
    dbg_addr = 4'd1;
    #1;
    tests_run++;
    if (dbg_data !== 32'h7FFF_FFFF) begin
      tests_failed++;
      $display("FAIL ovf_setup_r1: got %h expected 7fffffff", dbg_data);
    end
    dbg_addr = 4'd3;
    exec(mk(OpAdd, 4'd3, 4'd1, 4'd0, 1'b1, 14'd1));
    @(negedge clk);
    tests_run++;
    if ({dbg_data, ovf_flag} !== {32'h8000_0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL ovf_result: got r3=%h ovf=%b expected r3=80000000 ovf=1", dbg_data, ovf_flag);
    end
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ovf_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %b expected 0", ovf_flag);
    end
    // Clear coinciding with WB: the new overflow must win.
    send(mk(OpAdd, 4'd3, 4'd1, 4'd0, 1'b1, 14'd1));
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ovf_flag !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_clear_same_wb: got %b expected 1", ovf_flag);
    end
    @(posedge clk); #1 clear_flags = 1'b1;
    @(posedge clk); #1 clear_flags = 1'b0;
  endtask

  task automatic test_error;
    exec(mk(OpAdd, 4'd4, 4'd0, 4'd0, 1'b1, 14'd9));
    dbg_addr = 4'd4;
    send(mk(OpBad, 4'd4, 4'd1, 4'd2, 1'b0, 14'd0));
    @(negedge clk);  // T+1
    tests_run++;
    if ({alu_enable, alu_opcode} !== {1'b1, OpBad}) begin
      tests_failed++;
      $display("FAIL err_exec: got en=%b op=%h expected en=1 op=1f", alu_enable, alu_opcode);
    end
    @(negedge clk);  // T+2
    tests_run++;
    if ({done, done_err} !== 2'b11) begin
      tests_failed++;
      $display("FAIL err_done: got done/done_err=%b expected 11", {done, done_err});
    end
    @(negedge clk);  // T+3
    tests_run++;
    if ({dbg_data, err_flag, done_err} !== {32'd9, 2'b10}) begin
      tests_failed++;
      $display("FAIL err_result: got r4=%h err_flag=%b done_err=%b expected r4=9 err_flag=1 done_err=0",
               dbg_data, err_flag, done_err);
    end
  endtask

  task automatic test_r0_nop;
    exec(mk(OpAdd, 4'd5, 4'd0, 4'd0, 1'b1, 14'd11));
    exec(mk(OpAdd, 4'd0, 4'd1, 4'd0, 1'b1, 14'd7));
    dbg_addr = 4'd0;
    #1;
    tests_run++;
    if (dbg_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL r0_write: got %h expected 0", dbg_data);
    end
    dbg_addr = 4'd5;
    send(mk(OpNop, 4'd5, 4'd1, 4'd0, 1'b1, 14'd3));
    @(negedge clk);
    @(negedge clk);  // T+2
    tests_run++;
    if ({done, done_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL nop_done: got done/done_err=%b expected 10", {done, done_err});
    end
    @(negedge clk);
    tests_run++;
    if (dbg_data !== 32'd11) begin
      tests_failed++;
      $display("FAIL nop_r5: got %h expected b", dbg_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog [4];
    int acc_cyc [4];
    int k = 0;
    int dones = 0;
    logic acc_now;
    prog[0] = mk(OpAdd, 4'd7,  4'd0, 4'd0, 1'b1, 14'd1);
    prog[1] = mk(OpAdd, 4'd8,  4'd7, 4'd0, 1'b1, 14'd2);
    prog[2] = mk(OpAdd, 4'd9,  4'd8, 4'd0, 1'b1, 14'd3);
    prog[3] = mk(OpAdd, 4'd10, 4'd9, 4'd7, 1'b0, 14'd0);
    for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
    @(posedge clk); #1;
    instr = prog[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) dones++;
      acc_now = instr_valid && instr_ready;
      if (acc_now) acc_cyc[k] = c;
      @(posedge clk); #1;
      if (acc_now) begin
        k++;
        if (k < 4) instr = prog[k];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (acc_cyc[i] !== 3 * i) begin
        tests_failed++;
        $display("FAIL b2b_accept_%0d: got cycle %0d expected %0d", i, acc_cyc[i], 3 * i);
      end
    end
    tests_run++;
    if (dones !== 4) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d expected 4", dones);
    end
    dbg_addr = 4'd10;
    #1;
    tests_run++;
    if (dbg_data !== 32'd7) begin
      tests_failed++;
      $display("FAIL b2b_r10: got %h expected 7", dbg_data);
    end
  endtask

  task automatic test_reset_mid;
    dbg_addr = 4'd6;
    send(mk(OpAdd, 4'd6, 4'd0, 4'd0, 1'b1, 14'd5));
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (alu_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_in_exec: got en=%b expected 1", alu_enable);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({done, instr_ready, alu_enable, dbg_data} !== {3'b010, 32'h0}) begin
      tests_failed++;
      $display("FAIL rstmid_after: got done=%b ready=%b en=%b r6=%h expected done=0 ready=1 en=0 r6=0",
               done, instr_ready, alu_enable, dbg_data);
    end
    @(negedge clk);
    tests_run++;
    if ({done, dbg_data} !== 33'h0) begin
      tests_failed++;
      $display("FAIL rstmid_no_wb: got done=%b r6=%h expected done=0 r6=0", done, dbg_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = 32'h0;
    instr_valid = 1'b0;
    clear_flags = 1'b0;
    dbg_addr = 4'd0;
    test_reset();
    test_add();
    test_overflow();
    test_error();
    test_r0_nop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
